coverfloat_vector_sched: RTL
============================

// Module: coverfloat_vector_sched
// PURPOSE
//  Multi-source cover-vector scheduler placed ahead of the coverage sampler.
//  - Up to NSRC producers (file readers, reference models) each offer packed cover vectors.
//  - Round-robin arbitration picks one producer per cycle; accepted vectors are buffered in a FIFO.
//  - Vectors leave one per handshake to the single coverfloat_coverage sampling point.
//  - Run sequencing (start/drain/done) replaces ad-hoc end-of-file stop logic.
// PARAMETERS
//  NSRC   4                     number of requesters, 1..8
//  DEPTH  8                     FIFO entries, power of 2, >=2
//  VW     COVER_VECTOR_WIDTH    packed vector width (package constant)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  start      in   1         pulse: begin (or restart) a run
//  src_valid  in   NSRC      per-source vector valid
//  src_vec    in   NSRC*VW   per-source vector; source i at [i*VW +: VW]
//  src_last   in   NSRC      qualifies src_vec: final vector of source i
//  src_ready  out  NSRC      one-hot grant; transfer on src_valid[i]&src_ready[i]
//  smp_valid  out  1         vector available to sampler
//  smp_vec    out  VW        vector to sampler
//  smp_src    out  $clog2(NSRC) (min 1)  index of originating source
//  smp_ready  in   1         sampler accepts
//  busy       out  1         state is RUN or DRAIN
//  done       out  1         run complete, all vectors delivered
//  vec_count  out  32        vectors delivered this run
// BEHAVIOUR
//  Reset: state IDLE. rr pointer=0, finished flags=0, FIFO empty.
//   Outputs at reset: src_ready=0, smp_valid=0, smp_vec=0, smp_src=0, busy=0, done=0, vec_count=0.
//  FSM: IDLE -start-> RUN.
//   RUN -(all finished flags set)-> DRAIN.
//   DRAIN -(FIFO empty)-> DONE.
//   DONE -start-> RUN: same cycle clears finished flags, vec_count and rr pointer.
//   start ignored in RUN/DRAIN.
//  Grant (comb): only in RUN and FIFO not full.
//   Grant the first i, searching from rr pointer upward with wrap, where src_valid[i]=1 and finished[i]=0.
//   At most one bit of src_ready is set; src_ready depends on src_valid (no comb path from smp_ready).
//  On transfer from source i: push {i, vec} to FIFO; rr pointer <= (i+1) mod NSRC.
//   If src_last[i] is also set, finished[i] <= 1.
//   Later src_valid[i] is ignored until restart.
//  FIFO: registered.
//   Vector accepted in cycle t is visible on smp_vec no earlier than t+1; order is preserved.
//   Full: no grant, even if a pop happens in the same cycle.
//   Empty: smp_valid=0; smp_vec/smp_src hold their last value.
//   Simultaneous push+pop when not full: allowed, occupancy unchanged.
//  vec_count: +1 per smp_valid&smp_ready; 32-bit wrap to 0.
//  done: registered, 1 only in DONE. busy is likewise registered.
//  Reset mid-run: all state lost, buffered vectors discarded, outputs return to reset values.
// CONFIGURATION
//  COVERFLOAT_OP_FILTER_EN defined:
//   Extra ports op_drop_en (in 1), op_drop_code (in OP_W), drop_count (out 32, reset 0).
//   Applies when op_drop_en=1 and the vector op field (top OP_W bits) equals op_drop_code.
//   Such a vector is still granted and acknowledged, and its src_last is still honoured.
//   It is not pushed to the FIFO; drop_count +1; drop_count is cleared on restart.
//  COVERFLOAT_OP_FILTER_EN not defined:
//   Extra ports absent; every granted vector is pushed.
// STRUCTURE
//  coverfloat_pkg holds:
//   COVER_VECTOR_WIDTH, OP_W, and the op-field offset.
//   typedef enum logic [1:0] {SCH_IDLE, SCH_RUN, SCH_DRAIN, SCH_DONE} sched_state_t.
//  One sub-module: coverfloat_vec_fifo (param WIDTH, DEPTH; push/pop/full/empty, registered output).
//  Arbiter and FSM live in this module.
// TESTING
//  1. NSRC=4, all valid, FIFO never full, smp_ready=1:
//     grants cycle 0,1,2,3,0; smp_src sequence matches; vec_count=5 after 5 pops.
//  2. DEPTH=8, smp_ready=0, source 0 streams:
//     8 accepts, then src_ready=0; raise smp_ready -> the 8 vectors come out in order.
//  3. Each source sends 2 vectors, the second with src_last:
//     after 8 transfers, state DRAIN; after the FIFO empties, done=1 and vec_count=8.
//  4. rst_n low for one cycle mid-run with 3 vectors buffered:
//     smp_valid=0, busy=0, vec_count=0; no buffered vector is delivered afterwards.
//  5. start in DONE:
//     vec_count=0, finished cleared; sources are accepted again the next cycle.
//     start pulsed in RUN has no effect.
//  6. OP_FILTER_EN, op_drop_code=8'h03, mixed ops 03,01,03,02:
//     sampler receives only the 01 and 02 vectors; drop_count=2.

Source files
------------

// File: rtl/coverfloat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coverfloat_pkg
// Purpose  : Shared constants and types for the cover-vector scheduler.
//            Defines the packed cover-vector width, the op-field geometry and
//            the scheduler state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package coverfloat_pkg;

  localparam int COVER_VECTOR_WIDTH = 32;
  // The op field occupies the top OP_W bits of a cover vector.
  localparam int OP_W               = 8;
  localparam int OP_LSB             = COVER_VECTOR_WIDTH - OP_W;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_RUN   = 2'd1,
    SCH_DRAIN = 2'd2,
    SCH_DONE  = 2'd3
  } sched_state_t;

endpackage : coverfloat_pkg
`default_nettype wire

// File: rtl/coverfloat_vec_fifo.sv
`default_nettype none
// ============================================================================
// Module   : coverfloat_vec_fifo
// Purpose  : Synchronous FIFO with a registered head output. The head
//            register always holds the oldest entry while non-empty and
//            keeps its last value once the FIFO drains.
// Ports    : clk, rst_n      - clock / asynchronous active-low reset
//            push, din       - write request and data (ignored when full)
//            pop             - read request (ignored when empty)
//            dout            - registered head entry
//            full, empty     - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module coverfloat_vec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Head register: reload only when the oldest entry changes. When the
  // memory holds nothing beyond the entry leaving, the incoming word goes
  // straight to the head so it is visible the cycle after the push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (do_pop && (count > ONE_CNT)) begin
      dout <= mem[rd_ptr_nxt];
    end else if (do_push && (empty || (do_pop && (count == ONE_CNT)))) begin
      dout <= din;
    end
  end

endmodule : coverfloat_vec_fifo
`default_nettype wire

// File: rtl/coverfloat_vector_sched.sv
`default_nettype none
// ============================================================================
// Module   : coverfloat_vector_sched
// Purpose  : Multi-source cover-vector scheduler. Round-robin arbitration
//            across NSRC producers, FIFO buffering, single-handshake delivery
//            to the coverage sampler and start/drain/done run sequencing.
// Optional : COVERFLOAT_OP_FILTER_EN adds op_drop_en / op_drop_code inputs
//            and drop_count output; matching vectors are acknowledged but not
//            buffered.
// Ports    : clk, rst_n             - clock / asynchronous active-low reset
//            start                  - begin or restart a run (IDLE/DONE only)
//            src_valid/vec/last     - per-source offer, source i at [i*VW +: VW]
//            src_ready              - one-hot grant
//            smp_valid/vec/src      - sampler side, smp_ready accepts
//            busy, done             - registered run status
//            vec_count              - vectors delivered this run
// Revision : 1.0 - initial release
// ============================================================================
module coverfloat_vector_sched
  import coverfloat_pkg::*;
#(
  parameter  int NSRC  = 4,
  parameter  int DEPTH = 8,
  parameter  int VW    = COVER_VECTOR_WIDTH,
  localparam int SW    = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NSRC-1:0]    src_valid,
  input  logic [NSRC*VW-1:0] src_vec,
  input  logic [NSRC-1:0]    src_last,
  output logic [NSRC-1:0]    src_ready,
  output logic               smp_valid,
  output logic [VW-1:0]      smp_vec,
  output logic [SW-1:0]      smp_src,
  input  logic               smp_ready,
  output logic               busy,
  output logic               done,
  output logic [31:0]        vec_count
`ifdef COVERFLOAT_OP_FILTER_EN
  ,
  input  logic               op_drop_en,
  input  logic [OP_W-1:0]    op_drop_code,
  output logic [31:0]        drop_count
`endif
);

  sched_state_t     state;
  sched_state_t     state_nxt;
  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    grant_idx;
  logic             grant_any;
  logic [NSRC-1:0]  grant;
  logic [NSRC-1:0]  finished;
  logic [VW-1:0]    xfer_vec;
  logic             xfer_last;
  logic             restart;
  logic             grant_en;
  logic             busy_d;
  logic             done_d;
  logic             drop_hit;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [SW+VW-1:0] fifo_dout;

  // A start is only meaningful when no run is in flight.
  assign restart = start && ((state == SCH_IDLE) || (state == SCH_DONE));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      SCH_IDLE:  if (start)       state_nxt = SCH_RUN;
      SCH_RUN:   if (&finished)   state_nxt = SCH_DRAIN;
      SCH_DRAIN: if (fifo_empty)  state_nxt = SCH_DONE;
      SCH_DONE:  if (start)       state_nxt = SCH_RUN;
      default:                    state_nxt = SCH_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. busy/done are taken from the next state so the registered
  // copies line up with the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_en = (state == SCH_RUN) && !fifo_full;
    busy_d   = (state_nxt == SCH_RUN) || (state_nxt == SCH_DRAIN);
    done_d   = (state_nxt == SCH_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiter: first eligible source at or above rr_ptr, wrapping.
  // Depends only on src_valid and registered state, never on smp_ready.
  // --------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (grant_en) begin
      for (int k = 0; k < NSRC; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NSRC) begin
          idx = idx - NSRC;
        end
        if (!grant_any && src_valid[idx] && !finished[idx]) begin
          grant_any = 1'b1;
          grant_idx = SW'(idx);
        end
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign src_ready = grant;

  // Select the granted source's vector and last flag.
  always_comb begin
    xfer_vec  = '0;
    xfer_last = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) begin
        xfer_vec  = src_vec[i*VW +: VW];
        xfer_last = src_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      finished <= '0;
    end else if (restart) begin
      rr_ptr   <= '0;
      finished <= '0;
    end else if (grant_any) begin
      rr_ptr   <= (grant_idx == SW'(NSRC - 1)) ? '0 : grant_idx + SW'(1);
      finished <= finished | (grant & {NSRC{xfer_last}});
    end
  end

  // --------------------------------------------------------------------------
  // Optional op filter: dropped vectors are still acknowledged to the source.
  // --------------------------------------------------------------------------
`ifdef COVERFLOAT_OP_FILTER_EN
  assign drop_hit = op_drop_en && (xfer_vec[VW-OP_W +: OP_W] == op_drop_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (restart) begin
      drop_count <= '0;
    end else if (grant_any && drop_hit) begin
      drop_count <= drop_count + 32'd1;
    end
  end
`else
  assign drop_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Buffer and sampler interface
  // --------------------------------------------------------------------------
  assign fifo_push = grant_any && !drop_hit;
  assign fifo_pop  = smp_ready && !fifo_empty;

  coverfloat_vec_fifo #(
    .WIDTH (SW + VW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({grant_idx, xfer_vec}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign smp_valid = !fifo_empty;
  assign smp_vec   = fifo_dout[VW-1:0];
  assign smp_src   = fifo_dout[SW+VW-1:VW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count <= '0;
    end else if (restart) begin
      vec_count <= '0;
    end else if (fifo_pop) begin
      vec_count <= vec_count + 32'd1;
    end
  end

endmodule : coverfloat_vector_sched
`default_nettype wire
